interrupt_ctrl: RTL and testbench
=================================

# interrupt_ctrl

Parametrised interrupt controller for the core. It synchronises external interrupt lines and merges them with CSR-pending bits. It resolves eligibility against privilege, global enables and delegation, picks one interrupt by fixed priority, and presents it to the commit stage over a request/acknowledge handshake, followed by a programmable hold-off window. It sits beside the CSR file and feeds the trap logic at commit.

## Interface
- NUM_INT, 12, number of interrupt bits; ≥ 12; bits 0–11 follow standard mip/mie layout
- SYNC_STAGES, 2, flops per external-line synchroniser; ≥ 1
- HOLDOFF_CYCLES, 2, cycles after an ack during which no new request is raised; ≥ 0
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- i_ext_irq  in  NUM_INT  raw asynchronous level interrupt lines
- i_intp  in  NUM_INT  CSR-pending bits (mip, software-writable part)
- i_inte  in  NUM_INT  enable bits (mie)
- i_mideleg  in  NUM_INT  delegation; 1 = S-mode target
- i_ps  in  program_state_t  current privilege (priv), mstatus.MIE (mie), mstatus.SIE (sie)
- i_e  in  1  commit boundary can accept an interrupt this cycle
- i_int_ack  in  1  commit has taken the presented interrupt
- o_int  out  1  interrupt request to commit
- o_to_s  out  1  presented interrupt targets S-mode
- o_data  out  reg_data_t  cause value: MSB = 1, low bits = interrupt index, rest 0
- o_pending  out  NUM_INT  synchronised external lines, for the CSR file's mip view

## Operation
- **Synchronisation.** ext_s = i_ext_irq after SYNC_STAGES flops. Effective pending = i_intp | ext_s.
- **Readiness.** ready[i] = pending[i] & i_inte[i].
- **M-targeted eligibility** (mideleg[i] = 0): eligible when priv < M, or when priv = M and mie = 1.
- **S-targeted eligibility** (mideleg[i] = 1): eligible when priv = U, or when priv = S and sie = 1. Never eligible in M.
- **Priority.**
  - All M-targeted candidates outrank all S-targeted ones.
  - Within each group: 11, 3, 7, 9, 1, 5, then NUM_INT-1 down to 12, then the remaining low bits in descending order.
- **FSM states: IDLE, REQ, HOLD.**
  - IDLE: if i_e and any candidate exists, latch the winner's index and target, then go to REQ.
  - REQ:
    - o_int = 1. o_data and o_to_s are held stable for the whole of REQ.
    - i_int_ack = 1: if HOLDOFF_CYCLES > 0, go to HOLD and load the counter with HOLDOFF_CYCLES−1; otherwise go to IDLE.
    - Else, if the latched index is no longer eligible (pending, enable, delegation or privilege changed): withdraw and go to IDLE.
    - A newly arrived higher-priority interrupt does not change the latched cause. It is re-arbitrated after ack or withdraw.
  - HOLD: the counter decrements each cycle. Go to IDLE when it reaches 0 in that cycle.
- **Outside REQ:** o_int = 0. o_data and o_to_s hold their last latched values.
- **Pending bits are never cleared here.** Clearing is the CSR/device owner's job. Level semantics apply throughout.
- **i_int_ack outside REQ** is ignored. Verification flags it as a protocol error.

## Timing
- **Reset values:** state IDLE, o_int 0, o_to_s 0, o_data 0, o_pending 0, synchronisers 0, counter 0.
- **Reset mid-operation:** an asynchronous return to these values in any state, including REQ and HOLD.
- **External path:** i_ext_irq rising at edge t appears on o_pending at t+SYNC_STAGES. o_int is raised at the earliest one cycle later.
- **CSR path:** an eligible i_intp/i_inte condition sampled with i_e = 1 at edge t gives o_int = 1 after edge t (registered, one cycle).
- **Ack:** ack sampled at edge t with o_int = 1 drops o_int after t. The next o_int is no earlier than edge t+HOLDOFF_CYCLES+1.
- **Withdraw:** sampled at edge t drops o_int after t.
- **Ack and withdraw in the same cycle:** ack wins, and the trap is taken.
- **i_e low in IDLE:** no request is raised. i_e is ignored in REQ, so the request persists.

## Structure
- The shared package holds:
  - program_state_t and reg_data_t (existing)
  - priv encodings PRIV_U = 0, PRIV_S = 1, PRIV_M = 3
  - standard interrupt index constants (SSI 1, MSI 3, STI 5, MTI 7, SEI 9, MEI 11)
  - an interrupt-FSM state enum
- One sub-module, int_sync: a parametrised width×SYNC_STAGES flop chain with asynchronous active-high reset.
- Priority selection is combinational inside interrupt_ctrl, written as a function.

## Test plan
- priv = U, MTI pending and enabled, mideleg = 0, i_e = 1 → o_int after one cycle, o_data = MSB|7, o_to_s = 0. Ack → o_int low, silent for 2 cycles (default hold-off).
- MEI and MTI both pending, priv = M, mie = 1 → cause 11. After ack and hold-off with MEI cleared → cause 7.
- SEI delegated, priv = S, sie = 0 → no request. Set priv = U → request with o_to_s = 1, cause 9. Same SEI at priv = M → never raised.
- In REQ, clear i_inte[7] without ack → o_int falls the next cycle. Ack and withdraw in the same cycle → treated as ack, and HOLD is entered.
- Pulse i_ext_irq[11] (async level) → o_pending[11] exactly SYNC_STAGES edges later. Assert i_rst while in REQ → all outputs 0 immediately.
- NUM_INT = 16, HOLDOFF_CYCLES = 0, bits 12 and 13 pending (M-target) → cause 13 then 12. Back-to-back requests with only one idle cycle between them.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared core types and constants for the interrupt controller.
// Combinational definitions only: no latency, no flow control.
package interrupt_ctrl_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] reg_data_t;

    typedef struct packed {
        logic [1:0] priv;
        logic       mie;
        logic       sie;
    } program_state_t;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int IRQ_SSI = 1;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_STI = 5;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_SEI = 9;
    localparam int IRQ_MEI = 11;

    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        INT_REQ  = 2'd1,
        INT_HOLD = 2'd2
    } int_state_e;

endpackage

// File: rtl/interrupt_ctrl_sync.sv
// WIDTH-bit, STAGES-deep flop chain for asynchronous level lines.
// Latency STAGES cycles; free-running, no backpressure.
module int_sync #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_chain[s] <= r_chain[s-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: sync, eligibility, fixed-priority pick, req/ack to commit, hold-off.
// Request one cycle after an eligible sample with i_e; held until ack or withdraw, then HOLDOFF_CYCLES quiet.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int NUM_INT        = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_INT-1:0]  i_ext_irq,
    input  logic [NUM_INT-1:0]  i_intp,
    input  logic [NUM_INT-1:0]  i_inte,
    input  logic [NUM_INT-1:0]  i_mideleg,
    input  program_state_t      i_ps,
    input  logic                i_e,
    input  logic                i_int_ack,
    output logic                o_int,
    output logic                o_to_s,
    output reg_data_t           o_data,
    output logic [NUM_INT-1:0]  o_pending
);

    localparam int IDX_W     = $clog2(NUM_INT);
    localparam int CNT_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scans lowest priority first so the highest-priority hit is written last.
    function automatic pick_t pick_grp(input logic [NUM_INT-1:0] c);
        pick_t p;
        p = '0;
        for (int i = 0; i < 12; i += 2) begin
            if (c[i]) p = '{1'b1, IDX_W'(i)};
        end
        for (int i = 12; i < NUM_INT; i++) begin
            if (c[i]) p = '{1'b1, IDX_W'(i)};
        end
        if (c[IRQ_STI]) p = '{1'b1, IDX_W'(IRQ_STI)};
        if (c[IRQ_SSI]) p = '{1'b1, IDX_W'(IRQ_SSI)};
        if (c[IRQ_SEI]) p = '{1'b1, IDX_W'(IRQ_SEI)};
        if (c[IRQ_MTI]) p = '{1'b1, IDX_W'(IRQ_MTI)};
        if (c[IRQ_MSI]) p = '{1'b1, IDX_W'(IRQ_MSI)};
        if (c[IRQ_MEI]) p = '{1'b1, IDX_W'(IRQ_MEI)};
        return p;
    endfunction

    logic [NUM_INT-1:0] w_ext_s;
    logic [NUM_INT-1:0] w_ready;
    logic [NUM_INT-1:0] w_cand;
    logic               w_m_ok;
    logic               w_s_ok;
    pick_t              w_m_pick;
    pick_t              w_s_pick;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic               w_win_to_s;
    reg_data_t          w_cause;

    int_state_e         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_to_s;
    reg_data_t          r_data;
    logic [CNT_W-1:0]   r_cnt;

    int_sync #(
        .WIDTH  (NUM_INT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_ext_irq),
        .o_q   (w_ext_s)
    );

    assign w_ready = (i_intp | w_ext_s) & i_inte;
    assign w_m_ok  = (i_ps.priv != PRIV_M) | i_ps.mie;
    assign w_s_ok  = (i_ps.priv == PRIV_U) | ((i_ps.priv == PRIV_S) & i_ps.sie);
    assign w_cand  = w_ready & ((~i_mideleg & {NUM_INT{w_m_ok}}) | (i_mideleg & {NUM_INT{w_s_ok}}));

    assign w_m_pick   = pick_grp(w_cand & ~i_mideleg);
    assign w_s_pick   = pick_grp(w_cand & i_mideleg);
    assign w_win_vld  = w_m_pick.vld | w_s_pick.vld;
    assign w_win_to_s = ~w_m_pick.vld;
    assign w_win_idx  = w_m_pick.vld ? w_m_pick.idx : w_s_pick.idx;

    always_comb begin
        w_cause                 = '0;
        w_cause[XLEN-1]         = 1'b1;
        w_cause[IDX_W-1:0]      = w_win_idx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INT_IDLE;
            r_idx   <= '0;
            r_to_s  <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INT_IDLE: begin
                    if (i_e && w_win_vld) begin
                        r_state <= INT_REQ;
                        r_idx   <= w_win_idx;
                        r_to_s  <= w_win_to_s;
                        r_data  <= w_cause;
                    end
                end
                INT_REQ: begin
                    // Ack takes precedence over withdraw: the trap is already being taken.
                    if (i_int_ack) begin
                        if (HOLDOFF_CYCLES > 0) begin
                            r_state <= INT_HOLD;
                            r_cnt   <= CNT_W'(HOLD_LOAD);
                        end else begin
                            r_state <= INT_IDLE;
                        end
                    end else if (!w_cand[r_idx]) begin
                        r_state <= INT_IDLE;
                    end
                end
                INT_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= INT_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= INT_IDLE;
            endcase
        end
    end

    assign o_int     = (r_state == INT_REQ);
    assign o_to_s    = r_to_s;
    assign o_data    = r_data;
    assign o_pending = w_ext_s;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed vector table, hand sequences, randomized run against a reference model.
module tb_interrupt_ctrl;
    import interrupt_ctrl_pkg::*;

    localparam int HOLD = 2;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [11:0]    ext_irq = '0, intp = '0, inte = '0, mideleg = '0;
    program_state_t ps = '0;
    logic           e = 1'b0, ack = 1'b0;
    logic           o_int, o_to_s;
    reg_data_t      o_data;
    logic [11:0]    o_pending;

    logic [15:0]    i16_intp = '0, i16_inte = '0, i16_deleg = '0;
    program_state_t ps16 = '0;
    logic           e16 = 1'b0, ack16 = 1'b0;
    logic           o16_int, o16_to_s;
    reg_data_t      o16_data;
    logic [15:0]    o16_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_ctrl #(.NUM_INT(12), .SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(HOLD)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ext_irq(ext_irq), .i_intp(intp), .i_inte(inte),
        .i_mideleg(mideleg), .i_ps(ps), .i_e(e), .i_int_ack(ack),
        .o_int(o_int), .o_to_s(o_to_s), .o_data(o_data), .o_pending(o_pending)
    );

    interrupt_ctrl #(.NUM_INT(16), .SYNC_STAGES(2), .HOLDOFF_CYCLES(0)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_ext_irq(16'h0000), .i_intp(i16_intp), .i_inte(i16_inte),
        .i_mideleg(i16_deleg), .i_ps(ps16), .i_e(e16), .i_int_ack(ack16),
        .o_int(o16_int), .o_to_s(o16_to_s), .o_data(o16_data), .o_pending(o16_pending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int ORDER [12] = '{11, 3, 7, 9, 1, 5, 10, 8, 6, 4, 2, 0};

    function automatic bit elig(input int i, input logic [11:0] pend, en, deleg, input program_state_t p);
        if (!(pend[i] && en[i])) return 1'b0;
        if (deleg[i]) return (p.priv == PRIV_U) || (p.priv == PRIV_S && p.sie);
        return (p.priv < PRIV_M) || p.mie;
    endfunction

    logic [SYNC*12-1:0] m_hist;
    logic [11:0]        m_ext_s, m_pend;
    logic               m_req, m_to_s, m_win_s;
    int                 m_left, m_idx, m_win;
    logic [31:0]        m_data;
    bit                 model_on = 1'b0;

    assign m_ext_s = m_hist[SYNC*12-1 -: 12];
    assign m_pend  = intp | m_ext_s;

    always_comb begin
        m_win   = -1;
        m_win_s = 1'b0;
        for (int k = 0; k < 12; k++)
            if (m_win < 0 && !mideleg[ORDER[k]] && elig(ORDER[k], m_pend, inte, mideleg, ps)) m_win = ORDER[k];
        if (m_win < 0) begin
            for (int k = 0; k < 12; k++)
                if (m_win < 0 && mideleg[ORDER[k]] && elig(ORDER[k], m_pend, inte, mideleg, ps)) m_win = ORDER[k];
            m_win_s = (m_win >= 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist <= '0; m_req <= 1'b0; m_left <= 0; m_idx <= 0; m_to_s <= 1'b0; m_data <= '0;
        end else begin
            m_hist <= {m_hist[(SYNC-1)*12-1:0], ext_irq};
            if (m_req) begin
                if (ack) begin
                    m_req  <= 1'b0;
                    m_left <= HOLD;
                end else if (!elig(m_idx, m_pend, inte, mideleg, ps)) begin
                    m_req <= 1'b0;
                end
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (e && m_win >= 0) begin
                m_req  <= 1'b1;
                m_idx  <= m_win;
                m_to_s <= m_win_s;
                m_data <= 32'h8000_0000 | 32'(m_win);
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [11:0] intp, inte, deleg;
        logic [1:0]  priv;
        logic        mie, sie, e, ack;
        logic        x_int, x_to_s;
        logic [31:0] x_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [11:0] ip, ie, dl, input logic [1:0] pv,
                       input logic mi, si, ee, ak, xi, xs, input logic [31:0] xd);
        vec_t v;
        v.intp = ip; v.inte = ie; v.deleg = dl; v.priv = pv; v.mie = mi; v.sie = si;
        v.e = ee; v.ack = ak; v.x_int = xi; v.x_to_s = xs; v.x_data = xd;
        vecs.push_back(v);
    endtask

    localparam logic [11:0] MTI = 12'h080, MEI = 12'h800, SEI = 12'h200, NONE = 12'h000;
    localparam logic [31:0] D7 = 32'h8000_0007, D9 = 32'h8000_0009, D11 = 32'h8000_000B;

    initial begin
        // MTI from U: raise, ack, quiet, re-raise
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 0, 1, 0, D7);
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 1, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 0, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 0, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 0, 1, 0, D7);
        add(MTI, MTI, NONE, PRIV_U, 0, 0, 1, 1, 0, 0, D7);
        add(NONE, MTI, NONE, PRIV_U, 0, 0, 1, 0, 0, 0, D7);
        add(NONE, MTI, NONE, PRIV_U, 0, 0, 1, 0, 0, 0, D7);
        // MEI beats MTI in M; after ack with MEI cleared, MTI follows
        add(MEI|MTI, MEI|MTI, NONE, PRIV_M, 1, 0, 1, 0, 1, 0, D11);
        add(MEI|MTI, MEI|MTI, NONE, PRIV_M, 1, 0, 1, 1, 0, 0, D11);
        add(MTI, MEI|MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D11);
        add(MTI, MEI|MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D11);
        add(MTI, MEI|MTI, NONE, PRIV_M, 1, 0, 1, 0, 1, 0, D7);
        // withdraw on enable drop; then ack together with enable drop
        add(MTI, NONE, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_M, 1, 0, 1, 0, 1, 0, D7);
        add(MTI, NONE, NONE, PRIV_M, 1, 0, 1, 1, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D7);
        add(MTI, MTI, NONE, PRIV_M, 1, 0, 1, 0, 1, 0, D7);
        add(NONE, MTI, NONE, PRIV_M, 1, 0, 1, 1, 0, 0, D7);
        add(NONE, MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D7);
        add(NONE, MTI, NONE, PRIV_M, 1, 0, 1, 0, 0, 0, D7);
        // delegated SEI across privilege levels
        add(SEI, SEI, SEI, PRIV_S, 0, 0, 1, 0, 0, 0, D7);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 1, 0, 1, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 1, 1, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_M, 1, 0, 1, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_M, 1, 0, 1, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_M, 1, 1, 1, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_S, 0, 1, 1, 0, 1, 1, D9);
        // i_e gating in IDLE, ignored in REQ; latched cause not displaced by MEI
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 0, 1, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 0, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 0, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 0, 0, 0, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 1, 0, 1, 1, D9);
        add(SEI, SEI, SEI, PRIV_U, 0, 0, 0, 0, 1, 1, D9);
        add(SEI|MEI, SEI|MEI, SEI, PRIV_U, 0, 0, 1, 0, 1, 1, D9);
        add(SEI|MEI, SEI|MEI, SEI, PRIV_U, 0, 0, 1, 1, 0, 1, D9);
        add(SEI|MEI, SEI|MEI, SEI, PRIV_U, 0, 0, 1, 0, 0, 1, D9);
        add(SEI|MEI, SEI|MEI, SEI, PRIV_U, 0, 0, 1, 0, 0, 1, D9);
        add(SEI|MEI, SEI|MEI, SEI, PRIV_U, 0, 0, 1, 0, 1, 0, D11);
        add(SEI|MEI, NONE, SEI, PRIV_U, 0, 0, 1, 0, 0, 0, D11);

        // reset state
        repeat (2) @(negedge clk);
        check("rst o_int", 32'(o_int), 0);
        check("rst o_data", o_data, 0);
        check("rst o_to_s", 32'(o_to_s), 0);
        check("rst o_pending", 32'(o_pending), 0);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            intp = vecs[k].intp; inte = vecs[k].inte; mideleg = vecs[k].deleg;
            ps.priv = vecs[k].priv; ps.mie = vecs[k].mie; ps.sie = vecs[k].sie;
            e = vecs[k].e; ack = vecs[k].ack;
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d o_int", k), 32'(o_int), 32'(vecs[k].x_int));
            check($sformatf("vec%0d o_to_s", k), 32'(o_to_s), 32'(vecs[k].x_to_s));
            check($sformatf("vec%0d o_data", k), o_data, vecs[k].x_data);
        end

        // external line through the synchroniser, rise then fall
        intp = NONE; inte = MEI; mideleg = NONE; ps = '{PRIV_U, 1'b0, 1'b0}; e = 1'b1; ack = 1'b0;
        ext_irq = MEI;
        @(posedge clk); @(negedge clk);
        check("ext rise 1 edge", 32'(o_pending), 0);
        @(posedge clk); @(negedge clk);
        check("ext rise 2 edges", 32'(o_pending), 32'(MEI));
        check("ext no int yet", 32'(o_int), 0);
        @(posedge clk); @(negedge clk);
        check("ext int raised", 32'(o_int), 1);
        check("ext int cause", o_data, D11);
        ext_irq = NONE; inte = NONE;
        @(posedge clk); @(negedge clk);
        check("ext fall 1 edge", 32'(o_pending), 32'(MEI));
        @(posedge clk); @(negedge clk);
        check("ext fall 2 edges", 32'(o_pending), 0);

        // asynchronous reset while in REQ
        intp = SEI; inte = SEI; mideleg = SEI; ext_irq = 12'h008;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("pre-rst o_int", 32'(o_int), 1);
        check("pre-rst o_to_s", 32'(o_to_s), 1);
        check("pre-rst o_pending", 32'(o_pending), 32'h008);
        #2 rst = 1'b1;
        #1;
        check("mid-rst o_int", 32'(o_int), 0);
        check("mid-rst o_to_s", 32'(o_to_s), 0);
        check("mid-rst o_data", o_data, 0);
        check("mid-rst o_pending", 32'(o_pending), 0);
        @(negedge clk);
        rst = 1'b0; intp = NONE; inte = NONE; mideleg = NONE; ext_irq = NONE; e = 1'b0;

        // 16-bit instance, zero hold-off: upper bits, back-to-back
        ps16 = '{PRIV_M, 1'b1, 1'b0}; i16_inte = 16'hFFFF; i16_intp = 16'h3000; e16 = 1'b1;
        @(posedge clk); @(negedge clk);
        check("w16 first", 32'(o16_int), 1);
        check("w16 cause13", o16_data, 32'h8000_000D);
        ack16 = 1'b1; i16_intp = 16'h1000;
        @(posedge clk); @(negedge clk);
        check("w16 gap", 32'(o16_int), 0);
        ack16 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("w16 second", 32'(o16_int), 1);
        check("w16 cause12", o16_data, 32'h8000_000C);
        ack16 = 1'b1; i16_intp = 16'h1401;
        @(posedge clk); @(negedge clk);
        ack16 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("w16 12 over 10", o16_data, 32'h8000_000C);
        ack16 = 1'b1; i16_intp = 16'h0401;
        @(posedge clk); @(negedge clk);
        ack16 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("w16 10 over 0", o16_data, 32'h8000_000A);
        check("w16 to_s", 32'(o16_to_s), 0);
        check("w16 pending", 32'(o16_pending), 0);
        e16 = 1'b0; i16_intp = '0;

        // randomized run against the model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); @(negedge clk);
            check("rnd o_int", 32'(o_int), 32'(m_req));
            check("rnd o_to_s", 32'(o_to_s), 32'(m_to_s));
            check("rnd o_data", o_data, m_data);
            check("rnd o_pending", 32'(o_pending), 32'(m_ext_s));
            if ($urandom_range(0, 7) == 0) ext_irq[$urandom_range(0, 11)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) intp[$urandom_range(0, 11)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) inte[$urandom_range(0, 11)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) mideleg[$urandom_range(0, 11)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ps.priv = PRIV_U;
                    1:       ps.priv = PRIV_S;
                    default: ps.priv = PRIV_M;
                endcase
                ps.mie = 1'($urandom_range(0, 1));
                ps.sie = 1'($urandom_range(0, 1));
            end
            e   = ($urandom_range(0, 3) != 0);
            ack = m_req && ($urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
